// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module  : instruction_memory_loader
// Brief   : Packs a big-endian byte stream into 32-bit instruction words and
//           writes them to memory; holds the core in reset until done.
// Revision: 1.0 - initial release
// ============================================================================
module instruction_memory_loader #(
  parameter int MEM_BYTES = 188,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_words,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 core_hold,
  output logic                 load_done,
  output logic                 load_error
);

  localparam logic [CNT_WIDTH-1:0] MAX_WORDS = CNT_WIDTH'(MEM_BYTES / 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] word_idx;
  logic [1:0]           byte_idx;
  logic [23:0]          pack;

  logic start_ok;
  logic too_big;
  logic accept;
  logic last_word;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign too_big   = num_words > MAX_WORDS;
  assign accept    = byte_valid && (state == RECV);
  assign last_word = (word_idx + CNT_WIDTH'(1)) == target;

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    core_hold  = 1'b1;
    load_done  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          core_hold = 1'b0;
          load_done = 1'b1;
        end
        if (start_ok && !too_big)
          state_next = (num_words == '0) ? DONE : RECV;
      end
      RECV: begin
        byte_ready = 1'b1;
        if (accept && (byte_idx == 2'd3))
          state_next = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = last_word ? DONE : RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
      pack       <= 24'd0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      load_error <= 1'b0;
    end else begin
      state      <= state_next;
      load_error <= start_ok && too_big;
      if (start_ok && !too_big && (num_words != '0)) begin
        target   <= num_words;
        word_idx <= '0;
        byte_idx <= 2'd0;
      end
      // Bytes shift in from the bottom, so the first byte ends up in [31:24].
      if (accept) begin
        pack     <= {pack[15:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          mem_addr  <= 32'({word_idx, 2'b00});
          mem_wdata <= {pack, byte_in};
        end
      end
      if (state == WRITE)
        word_idx <= word_idx + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// Bench for instruction_memory_loader: directed loads, write scoreboard
// checked by an independent monitor on the falling edge.
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_words;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_memory_loader #(.MEM_BYTES(188), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every write must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      chk("ready_low_in_write", 32'(byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e[63:32]);
        chk("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start     = 1'b1;
    num_words = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    byte_in    = b;
    byte_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (byte_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    tick();
    byte_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (load_done !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("load_done_wait", 32'(load_done), 32'd1);
  endtask

  initial begin
    logic [7:0] t1 [4]  = '{8'hE3, 8'hA0, 8'h00, 8'h14};
    logic [7:0] t2 [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                            8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    logic [7:0] t6 [8]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
    rst = 1'b1; start = 1'b0; num_words = 8'd0; byte_in = 8'd0; byte_valid = 1'b0;
    do_reset();

    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   mem_addr,        32'd0);
    chk("rst_mem_wdata",  mem_wdata,       32'd0);
    chk("rst_core_hold",  32'(core_hold),  32'd1);
    chk("rst_load_done",  32'(load_done),  32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);

    // 1: single word, bytes back-to-back
    exp_q.push_back({32'd0, 32'hE3A00014});
    pulse_start(8'd1);
    foreach (t1[i]) send_byte(t1[i], 1'b0);
    chk("t1_write_cycle_we", 32'(mem_we), 32'd1);
    tick();
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_core_hold", 32'(core_hold), 32'd0);

    // 2: three words, valid toggling
    do_reset();
    exp_q.push_back({32'd0, 32'h01020304});
    exp_q.push_back({32'd4, 32'h05060708});
    exp_q.push_back({32'd8, 32'h090A0B0C});
    pulse_start(8'd3);
    foreach (t2[i]) send_byte(t2[i], 1'b1);
    wait_done();
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // 3: oversize request rejected
    do_reset();
    pulse_start(8'd48);
    chk("t3_error_pulse", 32'(load_error), 32'd1);
    chk("t3_core_hold",   32'(core_hold),  32'd1);
    tick();
    chk("t3_error_cleared", 32'(load_error), 32'd0);
    chk("t3_stay_idle",     32'(byte_ready), 32'd0);

    // 4: zero-length load
    pulse_start(8'd0);
    chk("t4_load_done", 32'(load_done), 32'd1);
    chk("t4_core_hold", 32'(core_hold), 32'd0);

    // 5: reset in the middle of a 2-word load
    do_reset();
    exp_q.push_back({32'd0, 32'h11223344});
    pulse_start(8'd2);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_byte_ready", 32'(byte_ready), 32'd0);
    chk("t5_core_hold",  32'(core_hold),  32'd1);
    chk("t5_one_write",  32'(exp_q.size()), 32'd0);
    exp_q.push_back({32'd0, 32'h01020304});
    pulse_start(8'd1);
    for (int i = 0; i < 4; i++) send_byte(t2[i], 1'b0);
    wait_done();

    // 6: restart from DONE, start during RECV ignored
    exp_q.push_back({32'd0, 32'hA1B2C3D4});
    exp_q.push_back({32'd4, 32'hE5F60718});
    pulse_start(8'd2);
    chk("t6_done_dropped", 32'(load_done), 32'd0);
    send_byte(t6[0], 1'b0);
    send_byte(t6[1], 1'b0);
    pulse_start(8'd1);
    chk("t6_no_error", 32'(load_error), 32'd0);
    for (int i = 2; i < 8; i++) send_byte(t6[i], 1'b0);
    wait_done();
    tick();
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
